// File: rtl/rotation_sequencer_pkg.sv
// Shared constants for the six-digit display rotation path.
// Latency: n/a (constants only).
// Backpressure: n/a (constants only).
package rotation_sequencer_pkg;

  // Default number of rotation positions (one per display digit).
  localparam int NUM_POS_DEF = 6;

  // Width of the character-select bus consumed by the display stage.
  localparam int CH_SEL_W = 3;

  // Code the display stage treats as blank; the sequencer never emits it.
  localparam logic [CH_SEL_W-1:0] CH_SEL_BLANK = 3'd7;

endpackage

// File: rtl/rotation_sequencer_tick_prescaler.sv
// Free-running prescaler: one-cycle tick every TICK_COUNT cycles while Run is high.
// Latency: tick is combinational in the TICK_COUNT-th cycle with Run high.
// Backpressure: none; Run low holds the count at zero.
module tick_prescaler #(
  parameter int TICK_COUNT = 50000000
) (
  input  logic CLOCK_50,
  input  logic Reset,
  input  logic Run,
  output logic tick
);

  localparam int CNT_W = (TICK_COUNT > 1) ? $clog2(TICK_COUNT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_COUNT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  // Next count: cleared while paused, wraps after the last position.
  always_comb begin
    count_d = count_q;
    if (!Run) begin
      count_d = '0;
    end else if (count_q == CNT_LAST) begin
      count_d = '0;
    end else begin
      count_d = count_q + CNT_ONE;
    end
  end

  // Count register; reset discards any partial interval.
  always_ff @(posedge CLOCK_50) begin
    if (Reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  // Dropping Run in the final cycle suppresses that tick.
  assign tick = Run & (count_q == CNT_LAST);

endmodule

// File: rtl/rotation_sequencer.sv
// Generates the display rotation select, advanced by prescaled tick or manual step.
// Latency: tick -> Ch_Sel 1 cycle; StepN fall -> Ch_Sel on the (SYNC_STAGES+1)-th edge.
// Backpressure: none; Advance is a one-cycle pulse the display consumes unconditionally.
module rotation_sequencer
  import rotation_sequencer_pkg::*;
#(
  parameter int TICK_COUNT  = 50000000,
  parameter int NUM_POS     = NUM_POS_DEF,
  parameter int SYNC_STAGES = 2
) (
  input  logic                CLOCK_50,
  input  logic                Reset,
  input  logic                Run,
  input  logic                Dir,
  input  logic                StepN,
  output logic [CH_SEL_W-1:0] Ch_Sel,
  output logic                Advance
);

  localparam logic [CH_SEL_W-1:0] POS_LAST = CH_SEL_W'(NUM_POS - 1);
  localparam logic [CH_SEL_W-1:0] POS_ONE  = CH_SEL_W'(1);

  logic                   tick;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   hist_q;
  logic                   sync_out;
  logic                   step_req;
  logic                   adv;
  logic [CH_SEL_W-1:0]    ch_sel_q;
  logic [CH_SEL_W-1:0]    ch_sel_d;
  logic                   advance_q;

  tick_prescaler #(
    .TICK_COUNT(TICK_COUNT)
  ) u_prescaler (
    .CLOCK_50(CLOCK_50),
    .Reset   (Reset),
    .Run     (Run),
    .tick    (tick)
  );

  // Button synchronizer plus edge history; reset loads "released" so a
  // button already held at reset looks like a fresh press only once.
  always_ff @(posedge CLOCK_50) begin
    if (Reset) begin
      sync_q <= '1;
      hist_q <= 1'b1;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], StepN};
      hist_q <= sync_out;
    end
  end

  assign sync_out = sync_q[SYNC_STAGES-1];
  assign step_req = hist_q & ~sync_out;

  // Manual steps only count while paused, so tick and step never collide.
  assign adv = tick | (step_req & ~Run);

  // Wrap counter: modulo NUM_POS in either direction, Dir sampled on adv only.
  always_comb begin
    ch_sel_d = ch_sel_q;
    if (adv) begin
      if (Dir) begin
        ch_sel_d = (ch_sel_q == '0) ? POS_LAST : ch_sel_q - POS_ONE;
      end else begin
        ch_sel_d = (ch_sel_q == POS_LAST) ? '0 : ch_sel_q + POS_ONE;
      end
    end
  end

  // Registered select and its change pulse, updated together.
  always_ff @(posedge CLOCK_50) begin
    if (Reset) begin
      ch_sel_q  <= '0;
      advance_q <= 1'b0;
    end else begin
      ch_sel_q  <= ch_sel_d;
      advance_q <= adv;
    end
  end

  assign Ch_Sel  = ch_sel_q;
  assign Advance = advance_q;

endmodule

// File: tb/tb_rotation_sequencer.sv
// Bench for rotation_sequencer with a four-cycle tick interval.
// Latency: expected advances queued with their edge number, checked each falling edge.
// Backpressure: n/a.
module tb_rotation_sequencer;

  logic       CLOCK_50;
  logic       Reset;
  logic       Run;
  logic       Dir;
  logic       StepN;
  logic [2:0] Ch_Sel;
  logic       Advance;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  typedef struct {
    int         edge_n;
    logic [2:0] ch;
  } exp_t;

  typedef struct {
    logic       dir;
    logic [2:0] exp_ch;
  } vec_t;

  exp_t q[$];
  vec_t tbl[17];

  rotation_sequencer #(
    .TICK_COUNT (4),
    .NUM_POS    (6),
    .SYNC_STAGES(2)
  ) dut (
    .CLOCK_50(CLOCK_50),
    .Reset   (Reset),
    .Run     (Run),
    .Dir     (Dir),
    .StepN   (StepN),
    .Ch_Sel  (Ch_Sel),
    .Advance (Advance)
  );

  initial CLOCK_50 = 1'b0;
  always #5 CLOCK_50 = ~CLOCK_50;

  always @(posedge CLOCK_50) cyc <= cyc + 1;

  function automatic logic [2:0] nxt(input logic [2:0] c, input logic d);
    int v;
    v = int'(c);
    v = d ? (v + 5) % 6 : (v + 1) % 6;
    return 3'(v);
  endfunction

  task automatic push(input int e, input logic [2:0] c);
    exp_t x;
    x.edge_n = e;
    x.ch     = c;
    q.push_back(x);
  endtask

  task automatic wait_to(input int e);
    while (cyc < e) begin
      @(posedge CLOCK_50);
      #1;
    end
  endtask

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (edge %0d)", name, act, exp, cyc);
    end
  endtask

  // Scoreboard: every falling edge either matches the queued advance or expects none.
  always @(negedge CLOCK_50) begin
    exp_t e;
    checks++;
    if (!(Ch_Sel < 3'd6)) begin
      failures++;
      $display("FAIL range: Ch_Sel=%0d outside 0..5 at edge %0d", Ch_Sel, cyc);
    end
    if (q.size() > 0 && q[0].edge_n == cyc) begin
      e = q.pop_front();
      checks++;
      if (Advance !== 1'b1 || Ch_Sel !== e.ch) begin
        failures++;
        $display("FAIL advance@%0d: got Advance=%0b Ch_Sel=%0d expected Advance=1 Ch_Sel=%0d",
                 cyc, Advance, Ch_Sel, e.ch);
      end
    end else begin
      checks++;
      if (Advance !== 1'b0) begin
        failures++;
        $display("FAIL spurious@%0d: got Advance=%0b Ch_Sel=%0d expected Advance=0",
                 cyc, Advance, Ch_Sel);
      end
    end
  end

  initial begin
    int       tick_edge;
    int       base;
    int       m;
    int       r;
    int       z;
    logic [2:0] exp_ch;
    logic [2:0] prev_ch;

    Reset = 1'b1;
    Run   = 1'b1;
    Dir   = 1'b0;
    StepN = 1'b1;

    // Per interval: Dir applied, Ch_Sel expected after that interval's tick.
    tbl[0]  = '{1'b0, 3'd1}; tbl[1]  = '{1'b0, 3'd2}; tbl[2]  = '{1'b0, 3'd3};
    tbl[3]  = '{1'b0, 3'd4}; tbl[4]  = '{1'b0, 3'd5}; tbl[5]  = '{1'b0, 3'd0};
    tbl[6]  = '{1'b0, 3'd1}; tbl[7]  = '{1'b1, 3'd0}; tbl[8]  = '{1'b1, 3'd5};
    tbl[9]  = '{1'b1, 3'd4}; tbl[10] = '{1'b1, 3'd3}; tbl[11] = '{1'b1, 3'd2};
    tbl[12] = '{1'b1, 3'd1}; tbl[13] = '{1'b1, 3'd0}; tbl[14] = '{1'b1, 3'd5};
    tbl[15] = '{1'b0, 3'd0}; tbl[16] = '{1'b0, 3'd1};

    // Reset held two cycles with Run high.
    wait_to(1);
    check("reset_ch_c1", int'(Ch_Sel), 0);
    check("reset_adv_c1", int'(Advance), 0);
    wait_to(2);
    check("reset_ch_c2", int'(Ch_Sel), 0);
    check("reset_adv_c2", int'(Advance), 0);
    Reset     = 1'b0;
    tick_edge = cyc;
    exp_ch    = 3'd0;

    // Automatic rotation, table-driven.
    for (int i = 0; i < 17; i++) begin
      Dir       = tbl[i].dir;
      tick_edge = tick_edge + 4;
      exp_ch    = tbl[i].exp_ch;
      push(tick_edge, exp_ch);
      wait_to(tick_edge);
    end
    check("table_end_ch", int'(Ch_Sel), 1);

    // Dir flips back mid-interval: spacing kept, forward step applied.
    Dir = 1'b1;
    wait_to(tick_edge + 2);
    Dir       = 1'b0;
    tick_edge = tick_edge + 4;
    exp_ch    = nxt(exp_ch, 1'b0);
    push(tick_edge, exp_ch);
    wait_to(tick_edge);

    // Button press while running is ignored.
    base  = tick_edge;
    StepN = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick_edge = tick_edge + 4;
      exp_ch    = nxt(exp_ch, 1'b0);
      push(tick_edge, exp_ch);
    end
    wait_to(base + 10);
    StepN = 1'b1;
    wait_to(tick_edge);
    check("run_step_ch", int'(Ch_Sel), 5);

    // Paused: mid-cycle press held 20 cycles gives one step on the 3rd edge.
    Run = 1'b0;
    wait_to(tick_edge + 3);
    @(posedge CLOCK_50);
    #3;
    StepN   = 1'b0;
    m       = cyc;
    prev_ch = exp_ch;
    exp_ch  = nxt(exp_ch, 1'b0);
    push(m + 3, exp_ch);
    wait_to(m + 2);
    check("step_not_early", int'(Ch_Sel), int'(prev_ch));
    wait_to(m + 20);
    StepN = 1'b1;
    wait_to(m + 26);
    check("step_fwd_ch", int'(Ch_Sel), 0);

    // Paused reverse step wraps 0 -> 5.
    Dir    = 1'b1;
    StepN  = 1'b0;
    m      = cyc;
    exp_ch = nxt(exp_ch, 1'b1);
    push(m + 3, exp_ch);
    wait_to(m + 8);
    StepN = 1'b1;
    wait_to(m + 14);
    check("step_rev_ch", int'(Ch_Sel), 5);

    // Run dropped in the final count cycle: tick suppressed.
    Dir = 1'b0;
    Run = 1'b1;
    r   = cyc;
    wait_to(r + 3);
    Run = 1'b0;
    wait_to(r + 9);
    check("drop_ch", int'(Ch_Sel), 5);
    check("drop_adv", int'(Advance), 0);
    Run       = 1'b1;
    tick_edge = cyc + 4;
    exp_ch    = nxt(exp_ch, 1'b0);
    push(tick_edge, exp_ch);
    wait_to(tick_edge);

    // Reset coinciding with a tick at Ch_Sel=3, button held low throughout.
    StepN = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick_edge = tick_edge + 4;
      exp_ch    = nxt(exp_ch, 1'b0);
      push(tick_edge, exp_ch);
    end
    wait_to(tick_edge);
    check("pre_reset_ch", int'(Ch_Sel), 3);
    wait_to(tick_edge + 3);
    Reset = 1'b1;
    wait_to(tick_edge + 4);
    check("reset_tick_ch", int'(Ch_Sel), 0);
    check("reset_tick_adv", int'(Advance), 0);
    Reset  = 1'b0;
    z      = cyc;
    exp_ch = 3'd1;
    push(z + 4, exp_ch);
    wait_to(z + 4);
    Run = 1'b0;
    wait_to(z + 12);
    check("held_low_no_step", int'(Ch_Sel), 1);
    StepN = 1'b1;
    wait_to(z + 16);

    check("queue_drained", q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/rotation_sequencer.md
Name: rotation_sequencer

Overview:
- Upstream control stage for the six-digit character display: it generates the 3-bit character-select (rotation amount 0..5) that the display mapping stage consumes in place of switches SW[9:7].
- It advances the rotation automatically from a prescaled tick, or manually by pushbutton when paused.
- Direction is selectable.
- The output drives the display stage's select input directly; the downstream encoding 0..5 is valid and 6/7 means blank, and this block never produces 6 or 7.

Parameters:
- TICK_COUNT, 50000000, clock cycles per automatic advance (1 s at 50 MHz); must be >= 2.
- NUM_POS, 6, number of rotation positions; Ch_Sel wraps modulo NUM_POS.
- SYNC_STAGES, 2, flip-flop stages in the StepN synchronizer; must be >= 2.

Ports:
- CLOCK_50  in  1  system clock; all state updates on its rising edge.
- Reset  in  1  synchronous, active-high reset.
- Run  in  1  1 = automatic rotation; 0 = paused, manual step enabled (level from a slide switch).
- Dir  in  1  0 = forward (Ch_Sel increments), 1 = reverse (Ch_Sel decrements).
- StepN  in  1  active-low pushbutton, asynchronous to CLOCK_50.
- Ch_Sel  out  3  current rotation select, registered, range 0..NUM_POS-1.
- Advance  out  1  registered one-cycle pulse, high in the same cycle Ch_Sel shows a new value.

Behaviour:
- Interface decision: one clock, CLOCK_50; Reset is synchronous and active-high.
- Reset:
  - Ch_Sel=0, Advance=0, prescaler count=0.
  - All synchronizer stages and the edge-history register are set to 1 (button released).
  - Reset overrides tick and step in the same cycle.
  - Reset mid-count discards the partial count; the next tick comes TICK_COUNT cycles after Reset deasserts, if Run=1.
- Prescaler:
  - Count width is clog2(TICK_COUNT).
  - While Run=1, count goes 0..TICK_COUNT-1 and then wraps to 0.
  - tick = Run & (count==TICK_COUNT-1), combinational.
  - While Run=0, count is forced to 0. After Run rises, the first tick is seen in the TICK_COUNT-th cycle with Run=1.
  - If Run drops in the cycle where count==TICK_COUNT-1, no tick is generated.
- Step path:
  - StepN passes through SYNC_STAGES flops, then an edge-history flop.
  - step_req = hist & ~sync_out, i.e. a falling edge of the synchronized button; at most one request per press.
  - Holding StepN low does not repeat.
  - No debounce in this block: each clean synchronized falling edge is one step.
  - step_req is ignored while Run=1.
- Advance:
  - adv = tick | (step_req & ~Run).
  - On adv with Dir=0: Ch_Sel <= (Ch_Sel==NUM_POS-1) ? 0 : Ch_Sel+1.
  - On adv with Dir=1: Ch_Sel <= (Ch_Sel==0) ? NUM_POS-1 : Ch_Sel-1.
  - Advance <= adv.
- Latency:
  - Tick → Ch_Sel/Advance: one cycle, updated on the edge ending the tick cycle.
  - StepN fall → Ch_Sel change: on the (SYNC_STAGES+1)-th rising edge after the fall, counting the first sampling edge as 1.
- Dir may change at any time; it is sampled only on the adv cycle and does not disturb the prescaler.
- tick and step_req cannot both be honoured in one cycle, because step is gated by ~Run. At most one position change per cycle.
- Ch_Sel never leaves 0..NUM_POS-1, including after reset and after any Dir/Run sequence.

Decomposition:
- Shared package: NUM_POS default, a CH_SEL_W=3 constant, and the blank-code constant (3'd7) the display stage uses. This block does not emit the blank code.
- One sub-module: tick_prescaler (CLOCK_50, Reset, Run → tick), parameterised by TICK_COUNT; reusable by later timed display stages.
- Synchronizer, edge detector and wrap counter stay inline.

Test Plan (TICK_COUNT=4 in simulation):
- Reset asserted for 2 cycles with Run=1 → Ch_Sel=0, Advance=0 throughout. After release, Advance pulses every 4 cycles with Ch_Sel 1,2,3,4,5,0,1.
- Run=1, Dir=1 from Ch_Sel=0 → next values 5,4,3. Flip Dir to 0 mid-interval → next advance keeps the 4-cycle spacing and gives +1.
- Run=0, StepN pulled low at a mid-cycle time and held 20 cycles → exactly one Advance, on the 3rd rising edge after the fall; Ch_Sel 0→1; StepN release produces no change.
- Run=1 with StepN pulsed low for 10 cycles → no extra advance; only tick-driven advances occur every 4 cycles.
- Run dropped in the cycle count==3 → no advance. Run raised again → first advance 4 cycles later.
- Reset asserted in the same cycle as a tick with Ch_Sel=3 → Ch_Sel=0, Advance=0; the held StepN low level produces no step after reset.
